// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, default widths and forwarding-select encoding shared by the ID/EX stage and ALU.
package alu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RA_W   = 5;
  localparam logic [5:0] FUNCT_ADDU = 6'h09;
  localparam logic [5:0] FUNCT_SUBU = 6'h0A;
  localparam logic [5:0] FUNCT_AND  = 6'h11;
  localparam logic [5:0] FUNCT_SLL  = 6'h21;
  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the youngest in-flight producer of a source register, falling back to the held value.
module fwd_mux import alu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W
) (
  input  logic [RA_W-1:0]   src_addr_i,
  input  logic [DATA_W-1:0] held_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [RA_W-1:0]   exmem_rd_addr_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [RA_W-1:0]   memwb_rd_addr_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] data_o,
  output fwd_sel_e          sel_o
);
  logic exmem_hit, memwb_hit;
  // r0 is hardwired zero, so a "write" to it must never be forwarded
  assign exmem_hit = exmem_reg_write_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == src_addr_i);
  assign memwb_hit = memwb_reg_write_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == src_addr_i);
  assign sel_o  = exmem_hit ? FWD_EXMEM : memwb_hit ? FWD_MEMWB : FWD_NONE;
  assign data_o = exmem_hit ? exmem_result_i : memwb_hit ? memwb_result_i : held_data_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: registers decoded operands/control ahead of the ALU, with forwarding, stall and flush.
module id_ex_stage import alu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [RA_W-1:0]   in_rs_addr,
  input  logic [RA_W-1:0]   in_rt_addr,
  input  logic [RA_W-1:0]   in_rd_addr,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic              in_reg_write,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   exmem_rd_addr,
  input  logic [RA_W-1:0]   memwb_rd_addr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_src1,
  output logic [DATA_W-1:0] ex_src2,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_funct,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic              ex_reg_write,
  output logic [1:0]        fwd_src1_sel,
  output logic [1:0]        fwd_src2_sel
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [RA_W-1:0]   rs_addr;
    logic [RA_W-1:0]   rt_addr;
    logic [RA_W-1:0]   rd_addr;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic              reg_write;
  } stage_t;
  stage_t stage_q, stage_d;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  fwd_sel_e rs_sel, rt_sel;
  logic is_sll;
  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
    .src_addr_i(stage_q.rs_addr), .held_data_i(stage_q.rs_data),
    .exmem_reg_write_i(exmem_reg_write), .exmem_rd_addr_i(exmem_rd_addr), .exmem_result_i(exmem_result),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_addr_i(memwb_rd_addr), .memwb_result_i(memwb_result),
    .data_o(rs_fwd), .sel_o(rs_sel)
  );
  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
    .src_addr_i(stage_q.rt_addr), .held_data_i(stage_q.rt_data),
    .exmem_reg_write_i(exmem_reg_write), .exmem_rd_addr_i(exmem_rd_addr), .exmem_result_i(exmem_result),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_addr_i(memwb_rd_addr), .memwb_result_i(memwb_result),
    .data_o(rt_fwd), .sel_o(rt_sel)
  );
  // a stall refreshes held operands so they survive the producer retiring past WB
  always_comb begin
    stage_d = stage_q;
    if (flush) stage_d = '0;
    else if (stall) begin
      stage_d.rs_data = rs_fwd;
      stage_d.rt_data = rt_fwd;
    end else
      stage_d = '{valid: in_valid, rs_data: in_rs_data, rt_data: in_rt_data,
                  rs_addr: in_rs_addr, rt_addr: in_rt_addr, rd_addr: in_rd_addr,
                  shamt: in_shamt, funct: in_funct, reg_write: in_reg_write & in_valid};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stage_q <= '0;
    else stage_q <= stage_d;
  assign is_sll       = stage_q.funct == FUNCT_SLL;
  assign ex_valid     = stage_q.valid;
  assign ex_src1      = !stage_q.valid ? '0 : is_sll ? rt_fwd : rs_fwd;
  assign ex_src2      = (!stage_q.valid || is_sll) ? '0 : rt_fwd;
  assign ex_funct     = stage_q.valid ? stage_q.funct : '0;
  assign ex_shamt     = stage_q.shamt;
  assign ex_rd_addr   = stage_q.rd_addr;
  assign ex_reg_write = stage_q.reg_write & stage_q.valid;
  assign fwd_src1_sel = rs_sel;
  assign fwd_src2_sel = rt_sel;
endmodule
